sid_write_scheduler: RTL and testbench

//  Shares the SID register write bus (WE/addr/data into sid_voices and the rest of the SID) between two

---
 rtl/sid_pkg.sv | 22 ++
 rtl/sid_write_scheduler_if.sv | 32 +++
 rtl/sid_wr_fifo.sv | 53 +++++
 rtl/sid_write_scheduler.sv | 96 +++++++++
 tb/tb_sid_write_scheduler.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sid_pkg.sv
// Shared SID register-bus constants and types for the write scheduler slice.
package sid_pkg;

    localparam int unsigned SID_ADDR_W    = 5;
    localparam int unsigned SID_DATA_W    = 8;
    localparam int unsigned SID_NUM_WREGS = 25;

    localparam logic [SID_ADDR_W-1:0] SID_REG_CTRL0 = 5'h04;
    localparam logic [SID_ADDR_W-1:0] SID_REG_CTRL1 = 5'h0B;
    localparam logic [SID_ADDR_W-1:0] SID_REG_CTRL2 = 5'h12;

    typedef struct packed {
        logic [SID_ADDR_W-1:0] addr;
        logic [SID_DATA_W-1:0] data;
    } sid_wr_t;

    typedef enum logic {
        PrioA = 1'b0,
        PrioB = 1'b1
    } sid_prio_e;

endpackage

// File: rtl/sid_write_scheduler_if.sv
// Bundle of requester, SID write bus and shadow readback signals of the write scheduler.
interface sid_write_scheduler_if;
    import sid_pkg::*;

    logic                  clkEn;
    logic                  iAValid;
    logic                  oAReady;
    logic [SID_ADDR_W-1:0] iAAddr;
    logic [SID_DATA_W-1:0] iAData;
    logic                  iBValid;
    logic                  oBReady;
    logic [SID_ADDR_W-1:0] iBAddr;
    logic [SID_DATA_W-1:0] iBData;
    logic                  oWE;
    logic [SID_ADDR_W-1:0] oAddr;
    logic [SID_DATA_W-1:0] oData;
    logic                  oDrop;
    logic [SID_ADDR_W-1:0] iRdAddr;
    logic [SID_DATA_W-1:0] oRdData;
    logic                  oBusy;

    modport slave (
        input  clkEn, iAValid, iAAddr, iAData, iBValid, iBAddr, iBData, iRdAddr,
        output oAReady, oBReady, oWE, oAddr, oData, oDrop, oRdData, oBusy
    );

    modport master (
        output clkEn, iAValid, iAAddr, iAData, iBValid, iBAddr, iBData, iRdAddr,
        input  oAReady, oBReady, oWE, oAddr, oData, oDrop, oRdData, oBusy
    );

endinterface

// File: rtl/sid_wr_fifo.sv
// Synchronous FIFO of {addr,data} register writes; pointers carry one extra wrap bit.
module sid_wr_fifo
    import sid_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic    clk,
    input  logic    iRstN,
    input  logic    push_i,
    input  sid_wr_t wdata_i,
    input  logic    pop_i,
    output sid_wr_t rdata_o,
    output logic    full_o,
    output logic    empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [PtrW:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW:0] rd_ptr_q, rd_ptr_d;
    sid_wr_t       mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    always_comb begin
        full_o   = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
        empty_o  = (wr_ptr_q == rd_ptr_q);
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q + (PtrW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (PtrW+1)'(do_pop);
        rdata_o  = mem_q[rd_ptr_q[PtrW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (!iRstN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: it is only read through a non-empty head.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PtrW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/sid_write_scheduler.sv
// Round-robin scheduler of two SID write queues onto one bus, one write per clkEn tick,
// with a registered shadow copy of the write-only registers.
module sid_write_scheduler
    import sid_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned NUM_WREGS = SID_NUM_WREGS
) (
    input logic                  clk,
    input logic                  iRstN,
    sid_write_scheduler_if.slave bus
);

    sid_wr_t   a_head, b_head, pop_entry;
    logic      a_full, a_empty, b_full, b_empty;
    logic      pop_a, pop_b, pick_a, do_pop;
    sid_prio_e prio_q, prio_d;
    logic      we_q, we_d;
    logic      drop_q, drop_d;
    logic [SID_ADDR_W-1:0] addr_q;
    logic [SID_DATA_W-1:0] data_q;
    logic [SID_DATA_W-1:0] rd_data_q, rd_data_d;
    logic [SID_DATA_W-1:0] shadow_q [NUM_WREGS];

    sid_wr_fifo #(.DEPTH(DEPTH)) u_fifo_a (
        .clk     (clk),
        .iRstN   (iRstN),
        .push_i  (bus.iAValid),
        .wdata_i ({bus.iAAddr, bus.iAData}),
        .pop_i   (pop_a),
        .rdata_o (a_head),
        .full_o  (a_full),
        .empty_o (a_empty)
    );

    sid_wr_fifo #(.DEPTH(DEPTH)) u_fifo_b (
        .clk     (clk),
        .iRstN   (iRstN),
        .push_i  (bus.iBValid),
        .wdata_i ({bus.iBAddr, bus.iBData}),
        .pop_i   (pop_b),
        .rdata_o (b_head),
        .full_o  (b_full),
        .empty_o (b_empty)
    );

    always_comb begin
        pick_a    = !a_empty && (b_empty || (prio_q == PrioA));
        pop_a     = bus.clkEn && pick_a;
        pop_b     = bus.clkEn && !b_empty && !pick_a;
        do_pop    = pop_a || pop_b;
        pop_entry = pick_a ? a_head : b_head;
        prio_d    = prio_q;
        if (do_pop) begin
            prio_d = pop_a ? PrioB : PrioA;
        end
        // Addresses past the writable range are popped but never reach the bus.
        we_d      = do_pop && (32'(pop_entry.addr) < NUM_WREGS);
        drop_d    = do_pop && !(32'(pop_entry.addr) < NUM_WREGS);
        rd_data_d = (32'(bus.iRdAddr) < NUM_WREGS) ? shadow_q[bus.iRdAddr] : '0;
    end

    always_ff @(posedge clk) begin
        if (!iRstN) begin
            prio_q    <= PrioA;
            we_q      <= 1'b0;
            drop_q    <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            rd_data_q <= '0;
            for (int i = 0; i < int'(NUM_WREGS); i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            prio_q    <= prio_d;
            we_q      <= we_d;
            drop_q    <= drop_d;
            rd_data_q <= rd_data_d;
            if (we_d) begin
                addr_q                   <= pop_entry.addr;
                data_q                   <= pop_entry.data;
                shadow_q[pop_entry.addr] <= pop_entry.data;
            end
        end
    end

    assign bus.oAReady = !a_full;
    assign bus.oBReady = !b_full;
    assign bus.oWE     = we_q;
    assign bus.oAddr   = addr_q;
    assign bus.oData   = data_q;
    assign bus.oDrop   = drop_q;
    assign bus.oRdData = rd_data_q;
    assign bus.oBusy   = !a_empty || !b_empty;

endmodule

// File: tb/tb_sid_write_scheduler.sv
// Directed and random checks of sid_write_scheduler against a queue-based reference model.
module tb_sid_write_scheduler;
    import sid_pkg::*;

    localparam int Depth = 4;
    localparam int NumW  = 25;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sid_write_scheduler_if bus ();

    sid_write_scheduler #(.DEPTH(Depth), .NUM_WREGS(NumW)) dut (
        .clk   (clk),
        .iRstN (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    sid_wr_t    qa[$];
    sid_wr_t    qb[$];
    bit         prio_b;
    logic [7:0] sh [NumW];
    logic       exp_we, exp_drop;
    logic [4:0] exp_addr;
    logic [7:0] exp_data, exp_rd;

    logic [12:0] wlog[$];
    int          drop_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        sid_wr_t e;
        bit      a_ok, b_ok, pa, pb;
        if (rst_n) begin
            chk("a_ready", 32'(bus.oAReady), 32'(qa.size() < Depth));
            chk("b_ready", 32'(bus.oBReady), 32'(qb.size() < Depth));
        end
        if (!rst_n) begin
            qa.delete();
            qb.delete();
            prio_b   = 1'b0;
            exp_we   = 1'b0;
            exp_drop = 1'b0;
            exp_rd   = 8'h00;
            for (int i = 0; i < NumW; i++) sh[i] = 8'h00;
        end else begin
            exp_rd   = (int'(bus.iRdAddr) < NumW) ? sh[bus.iRdAddr] : 8'h00;
            exp_we   = 1'b0;
            exp_drop = 1'b0;
            a_ok = bus.iAValid && (qa.size() < Depth);
            b_ok = bus.iBValid && (qb.size() < Depth);
            pa = bus.clkEn && (qa.size() > 0) && ((qb.size() == 0) || !prio_b);
            pb = bus.clkEn && (qb.size() > 0) && !pa;
            if (pa || pb) begin
                e = pa ? qa.pop_front() : qb.pop_front();
                prio_b = pa;
                if (int'(e.addr) < NumW) begin
                    exp_we      = 1'b1;
                    exp_addr    = e.addr;
                    exp_data    = e.data;
                    sh[e.addr]  = e.data;
                end else begin
                    exp_drop = 1'b1;
                end
            end
            if (a_ok) qa.push_back({bus.iAAddr, bus.iAData});
            if (b_ok) qb.push_back({bus.iBAddr, bus.iBData});
        end
        @(posedge clk);
        #1;
        chk("we", 32'(bus.oWE), 32'(exp_we));
        chk("drop", 32'(bus.oDrop), 32'(exp_drop));
        chk("rd_data", 32'(bus.oRdData), 32'(exp_rd));
        chk("busy", 32'(bus.oBusy), 32'((qa.size() + qb.size()) > 0));
        if (exp_we) begin
            chk("addr", 32'(bus.oAddr), 32'(exp_addr));
            chk("data", 32'(bus.oData), 32'(exp_data));
        end
        if (bus.oWE) wlog.push_back({bus.oAddr, bus.oData});
        if (bus.oDrop) drop_cnt++;
    endtask

    task automatic idle_inputs();
        bus.clkEn   = 1'b0;
        bus.iAValid = 1'b0;
        bus.iBValid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic run_en(input int cycles, input int period);
        for (int i = 0; i < cycles; i++) begin
            bus.clkEn = ((i % period) == period - 1);
            tick();
        end
        bus.clkEn = 1'b0;
    endtask

    logic [12:0] expw;

    initial begin
        bus.clkEn   = 1'b0;
        bus.iAValid = 1'b0;
        bus.iAAddr  = '0;
        bus.iAData  = '0;
        bus.iBValid = 1'b0;
        bus.iBAddr  = '0;
        bus.iBData  = '0;
        bus.iRdAddr = '0;
        drop_cnt    = 0;

        // Reset state
        do_reset();
        chk("rst_addr", 32'(bus.oAddr), 32'h0);
        chk("rst_data", 32'(bus.oData), 32'h0);
        chk("rst_a_ready", 32'(bus.oAReady), 32'h1);
        chk("rst_b_ready", 32'(bus.oBReady), 32'h1);

        // 1: single write, clkEn every 4th cycle
        bus.iAValid = 1'b1; bus.iAAddr = 5'h01; bus.iAData = 8'h1C;
        tick();
        bus.iAValid = 1'b0;
        run_en(12, 4);
        chk("t1_count", 32'(wlog.size()), 32'd1);
        if (wlog.size() > 0) chk("t1_entry", 32'(wlog[0]), 32'({5'h01, 8'h1C}));
        bus.iRdAddr = 5'h01;
        tick();
        chk("t1_shadow", 32'(bus.oRdData), 32'h1C);

        // 2: interleaved A/B issue order starting from A after reset
        do_reset();
        wlog.delete();
        for (int k = 0; k < 3; k++) begin
            bus.iAValid = 1'b1; bus.iAAddr = 5'(2 + k); bus.iAData = 8'(8'hA0 + k);
            bus.iBValid = 1'b1; bus.iBAddr = 5'(8 + k); bus.iBData = 8'(8'hB0 + k);
            tick();
        end
        idle_inputs();
        run_en(14, 2);
        chk("t2_count", 32'(wlog.size()), 32'd6);
        for (int k = 0; k < 6 && k < wlog.size(); k++) begin
            expw = (k % 2 == 0) ? {5'(2 + k / 2), 8'(8'hA0 + k / 2)}
                                : {5'(8 + k / 2), 8'(8'hB0 + k / 2)};
            chk("t2_order", 32'(wlog[k]), 32'(expw));
        end

        // 3: fill A with clkEn low, fifth entry waits for the first pop
        wlog.delete();
        for (int i = 0; i < 4; i++) begin
            bus.iAValid = 1'b1; bus.iAAddr = 5'(8'h0E + i); bus.iAData = 8'(8'h30 + i);
            tick();
        end
        chk("t3_full", 32'(bus.oAReady), 32'h0);
        bus.iAAddr = 5'h12; bus.iAData = 8'h34; bus.clkEn = 1'b1;
        tick();
        bus.clkEn = 1'b0;
        tick();
        bus.iAValid = 1'b0;
        run_en(12, 2);
        chk("t3_count", 32'(wlog.size()), 32'd5);
        for (int k = 0; k < 5 && k < wlog.size(); k++) begin
            expw = {5'(8'h0E + k), 8'(8'h30 + k)};
            chk("t3_order", 32'(wlog[k]), 32'(expw));
        end

        // 4: out-of-range address is dropped
        wlog.delete();
        drop_cnt = 0;
        bus.iBValid = 1'b1; bus.iBAddr = 5'h1B; bus.iBData = 8'h77;
        tick();
        bus.iBValid = 1'b0;
        run_en(6, 3);
        chk("t4_drops", 32'(drop_cnt), 32'd1);
        chk("t4_no_we", 32'(wlog.size()), 32'd0);

        // 5: shadow readback
        bus.iAValid = 1'b1; bus.iAAddr = SID_REG_CTRL0; bus.iAData = 8'h41;
        tick();
        bus.iAValid = 1'b0;
        run_en(4, 2);
        bus.iRdAddr = 5'h04;
        tick();
        chk("t5_rd", 32'(bus.oRdData), 32'h41);
        bus.iRdAddr = 5'h1D;
        tick();
        chk("t5_rd_oob", 32'(bus.oRdData), 32'h00);

        // 6: reset discards queued writes and restores A priority
        for (int i = 0; i < 3; i++) begin
            bus.iAValid = 1'b1; bus.iAAddr = SID_REG_CTRL1; bus.iAData = 8'(i);
            bus.iBValid = 1'b1; bus.iBAddr = SID_REG_CTRL2; bus.iBData = 8'(i);
            tick();
        end
        do_reset();
        wlog.delete();
        chk("t6_busy", 32'(bus.oBusy), 32'h0);
        run_en(8, 1);
        chk("t6_no_we", 32'(wlog.size()), 32'd0);
        bus.iRdAddr = 5'h04;
        tick();
        chk("t6_rd", 32'(bus.oRdData), 32'h00);
        bus.iAValid = 1'b1; bus.iAAddr = 5'h02; bus.iAData = 8'h5A;
        bus.iBValid = 1'b1; bus.iBAddr = 5'h03; bus.iBData = 8'hA5;
        tick();
        idle_inputs();
        run_en(4, 1);
        chk("t6_count", 32'(wlog.size()), 32'd2);
        if (wlog.size() > 0) chk("t6_prio", 32'(wlog[0]), 32'({5'h02, 8'h5A}));

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            bus.clkEn   = ($urandom_range(0, 2) == 0);
            bus.iAValid = ($urandom_range(0, 1) == 0);
            bus.iAAddr  = 5'($urandom_range(0, 31));
            bus.iAData  = 8'($urandom);
            bus.iBValid = ($urandom_range(0, 1) == 0);
            bus.iBAddr  = 5'($urandom_range(0, 31));
            bus.iBData  = 8'($urandom);
            bus.iRdAddr = 5'($urandom_range(0, 31));
            rst_n       = ($urandom_range(0, 99) != 0);
            tick();
        end
        rst_n = 1'b1;
        idle_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
